mem_sram_stage: RTL and testbench



---
 rtl/mem_sram_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_sram_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_stage.sv
// mem_sram_stage
// MEM stage of the 5-stage ARM pipeline. It turns an LDR/STR into two
// 16-bit accesses on an external asynchronous SRAM (low halfword first,
// then high halfword) and holds the pipeline with ready=0 while the
// access is in progress.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active-low
//   MEM_R_EN   - load request, held stable while ready=0
//   MEM_W_EN   - store request, held stable while ready=0 (wins over load)
//   ALU_Res    - byte address of the access
//   Val_Rm     - store data
//   Data_Out   - 32-bit load result, valid in DONE, held until next load
//   ready      - high when the stage is not stalling the pipeline
//   SRAM_ADDR  - halfword address to the SRAM
//   SRAM_WE_N  - SRAM write enable, active-low
//   SRAM_DQ    - bidirectional SRAM data bus
module mem_sram_stage #(
    parameter logic [31:0] ADDR_BASE   = 32'd1024,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_Res,
    input  logic [31:0]        Val_Rm,
    output logic [31:0]        Data_Out,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    inout  wire  [15:0]        SRAM_DQ
);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam int             CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WAIT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [29:0]          idx_q, idx_d;
    logic [31:0]          data_q, data_d;
    logic                 wr_q, wr_d;
    logic [SRAM_AW-1:0]   addr_q, addr_d;
    logic [31:0]          dout_q, dout_d;

    logic                 req;
    logic                 terminal;
    logic [29:0]          idx_in;
    logic [30:0]          lo_new, hi_cur;
    logic                 drive_bus;
    logic [15:0]          dq_out;

    assign req      = MEM_R_EN | MEM_W_EN;
    assign terminal = (cnt_q == LAST);

    // Word index relative to the data-memory base; the subtract wraps and
    // no range check is made, the result is simply truncated to the SRAM.
    assign idx_in = 30'((ALU_Res - ADDR_BASE) >> 2);
    assign lo_new = {idx_in, 1'b0};
    assign hi_cur = {idx_q, 1'b1};

    // Next-state logic. The SRAM address is registered: it is loaded with the
    // low halfword address on entry to LOW and the high one on entry to HIGH,
    // so it is stable for the whole wait window and holds afterwards.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    idx_d   = idx_in;
                    data_d  = Val_Rm;
                    wr_d    = MEM_W_EN;
                    addr_d  = SRAM_AW'(lo_new);
                end
            end
            LOW: begin
                if (terminal) begin
                    cnt_d   = '0;
                    state_d = HIGH;
                    addr_d  = SRAM_AW'(hi_cur);
                    if (!wr_q) begin
                        dout_d[15:0] = SRAM_DQ;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (terminal) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (!wr_q) begin
                        dout_d[31:16] = SRAM_DQ;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // A request still held in DONE is the one just served; the
            // pipeline advances this cycle, so it must not be re-launched.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
        end
    end

    // ready drops in the same cycle a request appears in IDLE so the
    // pipeline freezes before the access is even launched.
    always_comb begin
        ready = 1'b0;
        unique case (state_q)
            IDLE:    ready = ~req;
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Write strobe and bus drive come straight from the state register so a
    // reset releases the bus immediately, without waiting for a clock.
    assign drive_bus = wr_q && ((state_q == LOW) || (state_q == HIGH));
    assign dq_out    = (state_q == HIGH) ? data_q[31:16] : data_q[15:0];
    assign SRAM_DQ   = drive_bus ? dq_out : 16'hzzzz;
    assign SRAM_WE_N = ~drive_bus;
    assign SRAM_ADDR = addr_q;
    assign Data_Out  = dout_q;

endmodule

// File: tb/tb_mem_sram_stage.sv
// tb_mem_sram_stage
// Two instances of mem_sram_stage (WAIT_CYCLES=2 and WAIT_CYCLES=1), each
// with its own SRAM model. Stimulus pushes expected SRAM writes and expected
// completions (Data_Out plus stall length) into queues; monitors pop and
// compare when the DUT writes the SRAM or finishes an access.
module tb_mem_sram_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit unit_done [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=event required=none", name);
    endtask

    for (genvar g = 0; g < 2; g++) begin : unit
        localparam int WC = (g == 0) ? 2 : 1;

        logic        rst_n = 1'b0;
        logic        r_en  = 1'b0;
        logic        w_en  = 1'b0;
        logic [31:0] alu   = '0;
        logic [31:0] rm    = '0;
        wire  [31:0] dout;
        wire         rdy;
        wire         we_n;
        wire  [17:0] saddr;
        tri   [15:0] dq;

        logic [15:0] mem [0:1023];
        logic [33:0] exp_wr[$];
        logic [39:0] exp_done[$];
        int          low_cnt  = 0;
        logic        prev_rdy = 1'b1;

        mem_sram_stage #(
            .ADDR_BASE  (32'd1024),
            .SRAM_AW    (18),
            .WAIT_CYCLES(WC)
        ) dut (
            .clk      (clk),
            .rst      (rst_n),
            .MEM_R_EN (r_en),
            .MEM_W_EN (w_en),
            .ALU_Res  (alu),
            .Val_Rm   (rm),
            .Data_Out (dout),
            .ready    (rdy),
            .SRAM_ADDR(saddr),
            .SRAM_WE_N(we_n),
            .SRAM_DQ  (dq)
        );

        // SRAM model: drives the bus whenever it is not being written.
        initial begin
            for (int i = 0; i < 1024; i++) mem[i] = 16'h5A00 + 16'(i);
        end
        assign dq = we_n ? mem[saddr[9:0]] : 16'hzzzz;
        always @(posedge clk) begin
            if (we_n == 1'b0) mem[saddr[9:0]] <= dq;
        end

        // Monitor: every write cycle and every completion is checked against
        // the queues filled by the stimulus.
        always @(negedge clk) begin
            logic [33:0] ew;
            logic [39:0] ed;
            if (we_n == 1'b0) begin
                if (exp_wr.size() == 0) fail_now("unexpected_write");
                else begin
                    ew = exp_wr.pop_front();
                    check("sram_write", {30'd0, saddr, dq}, {30'd0, ew});
                end
            end
            if (!rst_n) begin
                low_cnt <= 0;
            end else if (!rdy) begin
                low_cnt <= low_cnt + 1;
            end else if (!prev_rdy) begin
                if (exp_done.size() == 0) fail_now("unexpected_completion");
                else begin
                    ed = exp_done.pop_front();
                    check("data_out", {32'd0, dout}, {32'd0, ed[31:0]});
                    check("stall_len", 64'(low_cnt), {56'd0, ed[39:32]});
                end
                low_cnt <= 0;
            end
            prev_rdy <= rdy;
        end

        // Issue one access at posedge+1 and return at posedge+1 after the
        // cycle in which ready came back high. Address/data are scrambled
        // once the access is launched to show latched values are used.
        task automatic applyStimulus(input bit r, input bit w, input logic [31:0] a,
                                     input logic [31:0] d, input logic [17:0] lo,
                                     input logic [31:0] exp_dout);
            int n;
            if (w) begin
                for (int k = 0; k < WC; k++) exp_wr.push_back({lo, d[15:0]});
                for (int k = 0; k < WC; k++) exp_wr.push_back({lo | 18'd1, d[31:16]});
            end
            exp_done.push_back({8'(2 * WC + 1), exp_dout});
            r_en = r;
            w_en = w;
            alu  = a;
            rm   = d;
            @(negedge clk);
            @(posedge clk);
            #1;
            alu = ~a;
            rm  = ~d;
            n = 0;
            @(negedge clk);
            while (rdy !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) fail_now("ready_timeout");
            @(posedge clk);
            #1;
            r_en = 1'b0;
            w_en = 1'b0;
        endtask

        task automatic checkOutput();
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("idle_ready", {63'd0, rdy}, 64'd1);
                check("idle_we_n", {63'd0, we_n}, 64'd1);
            end
            check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
            check("done_queue_empty", 64'(exp_done.size()), 64'd0);
        endtask

        if (g == 0) begin : seq
            initial begin
                repeat (2) @(negedge clk);
                check("rst_dout", {32'd0, dout}, 64'd0);
                check("rst_addr", {46'd0, saddr}, 64'd0);
                check("rst_we_n", {63'd0, we_n}, 64'd1);
                check("rst_ready", {63'd0, rdy}, 64'd1);
                check("rst_bus_released", {48'd0, dq}, 64'h5A00);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("idle_ready", {63'd0, rdy}, 64'd1);
                    check("idle_we_n", {63'd0, we_n}, 64'd1);
                    check("idle_dout", {32'd0, dout}, 64'd0);
                end
                @(posedge clk);
                #1;
                applyStimulus(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 18'd4, 32'h0);
                check("mem4", {48'd0, mem[4]}, 64'hBEEF);
                check("mem5", {48'd0, mem[5]}, 64'hDEAD);
                applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0, 18'd4, 32'hDEADBEEF);
                applyStimulus(1'b0, 1'b1, 32'd1024, 32'h11112222, 18'd0, 32'hDEADBEEF);
                applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 32'h11112222);
                repeat (5) @(posedge clk);
                #1;
                applyStimulus(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 18'h3FE00, 32'h11112222);

                // Store aborted by reset in the first HIGH cycle.
                exp_wr.push_back({18'd8, 16'hF00D});
                exp_wr.push_back({18'd8, 16'hF00D});
                r_en = 1'b0;
                w_en = 1'b1;
                alu  = 32'd1040;
                rm   = 32'h0BADF00D;
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b0;
                #1;
                check("abort_we_n", {63'd0, we_n}, 64'd1);
                check("abort_ready_req", {63'd0, rdy}, 64'd0);
                check("abort_dout", {32'd0, dout}, 64'd0);
                check("abort_addr", {46'd0, saddr}, 64'd0);
                check("abort_bus_released", {48'd0, dq}, 64'h2222);
                w_en = 1'b0;
                #1;
                check("abort_ready_noreq", {63'd0, rdy}, 64'd1);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                check("abort_mem8", {48'd0, mem[8]}, 64'hF00D);
                check("abort_mem9", {48'd0, mem[9]}, 64'h5A09);
                applyStimulus(1'b1, 1'b0, 32'd1040, 32'h0, 18'd8, 32'h5A09F00D);
                checkOutput();
                unit_done[0] = 1'b1;
            end
        end else begin : seq
            initial begin
                repeat (2) @(negedge clk);
                check("w1_rst_dout", {32'd0, dout}, 64'd0);
                check("w1_rst_ready", {63'd0, rdy}, 64'd1);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0, 18'd2, 32'h5A035A02);
                applyStimulus(1'b1, 1'b1, 32'd1028, 32'h12345678, 18'd2, 32'h5A035A02);
                check("w1_mem2", {48'd0, mem[2]}, 64'h5678);
                check("w1_mem3", {48'd0, mem[3]}, 64'h1234);
                applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0, 18'd2, 32'h12345678);
                checkOutput();
                unit_done[1] = 1'b1;
            end
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(unit_done[0] && unit_done[1]) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 20000) fail_now("bench_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
